// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory.
// The fetch stage is the master; the memory answers with imem_ready/imem_rdata.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: sequential fetch, one-entry stall buffer, and
// jump/branch redirect resolved against the instruction held in IF/ID.
module if_stage (
    input  logic              clk,
    input  logic              rst,
    if_stage_if.master        imem,
    input  logic              stall,
    input  logic              jump,
    input  logic              jr,
    input  logic              beq,
    input  logic              bne,
    input  logic              blez,
    input  logic              bgtz,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    output logic [31:0]       instr_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic              valid_o,
    output logic [1:0]        state_o
);
    // Bus handshake: a fetch completes on any rising edge where imem_req and
    // imem_ready are both 1; imem_req/imem_addr stay fixed until that edge.

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] target_q;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;

    logic        fire;
    logic        taken;
    logic        redirect;
    logic [31:0] branch_off;
    logic [31:0] target;
    logic [31:0] target_al;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign fire           = req_q && imem.imem_ready;

    assign op_o    = instr_o[31:26];
    assign funct_o = instr_o[5:0];
    assign state_o = state;

    assign taken = jr || jump
                || (beq  && (rs_data == rt_data))
                || (bne  && (rs_data != rt_data))
                || (blez && (rs_data[31] || (rs_data == 32'd0)))
                || (bgtz && (!rs_data[31] && (rs_data != 32'd0)));

    // Only a live instruction that decode is actually accepting may redirect.
    assign redirect   = valid_o && !stall && taken;
    assign branch_off = {{14{instr_o[15]}}, instr_o[15:0], 2'b00};

    always_comb begin
        target = pc_plus4_o + branch_off;
        if (jr)
            target = rs_data;
        else if (jump)
            target = {pc_plus4_o[31:28], instr_o[25:0], 2'b00};
    end

    assign target_al = {target[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            req_q      <= 1'b0;
            addr_q     <= 32'h0000_3000;
            target_q   <= 32'h0000_3000;
            buf_instr  <= 32'd0;
            buf_pc     <= 32'd0;
            instr_o    <= 32'd0;
            pc_o       <= 32'd0;
            pc_plus4_o <= 32'd4;
            valid_o    <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    req_q <= 1'b1;
                    if (redirect) begin
                        valid_o <= 1'b0;
                        if (fire) begin
                            addr_q <= target_al;
                        end else begin
                            // The outstanding request cannot be withdrawn; drain it first.
                            target_q <= target_al;
                            state    <= S_DROP;
                        end
                    end else if (fire) begin
                        addr_q <= addr_q + 32'd4;
                        if (stall) begin
                            buf_instr <= imem.imem_rdata;
                            buf_pc    <= addr_q;
                            req_q     <= 1'b0;
                            state     <= S_HOLD;
                        end else begin
                            instr_o    <= imem.imem_rdata;
                            pc_o       <= addr_q;
                            pc_plus4_o <= addr_q + 32'd4;
                            valid_o    <= 1'b1;
                        end
                    end else if (!stall) begin
                        valid_o <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        valid_o <= 1'b0;
                        addr_q  <= target_al;
                        req_q   <= 1'b1;
                        state   <= S_REQ;
                    end else if (!stall) begin
                        instr_o    <= buf_instr;
                        pc_o       <= buf_pc;
                        pc_plus4_o <= buf_pc + 32'd4;
                        valid_o    <= 1'b1;
                        req_q      <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_DROP: begin
                    valid_o <= 1'b0;
                    req_q   <= 1'b1;
                    if (fire) begin
                        addr_q <= target_q;
                        state  <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                    req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
